stage_id: RTL and testbench

Instruction-decode stage of the br32 five-stage pipeline. It sits directly downstream of the fetch stage:
- latches the fetch stage's `if_out_t` into its pipeline register;
- decodes the instruction and reads the 32×32 register file, with bypasses;
- resolves branches and jumps in decode;
- detects load-use hazards.

It drives `id_out_t`. Fetch consumes `branch`, `branch_dest` and `stall` from it; execute consumes the rest.

---
 rtl/pipeline_pkg.sv | 48 ++++
 rtl/stage_id_regfile.sv | 19 +
 rtl/stage_id.sv | 80 ++++++++
 tb/tb_stage_id.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared br32 pipeline stage types, opcodes and ALU operations
package pipeline_pkg;
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0B;
  localparam logic [5:0] OP_XORI = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_BNE  = 6'h19;
  localparam logic [5:0] OP_JAL  = 6'h1A;
  localparam logic [5:0] OP_JR   = 6'h1B;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] instr;
    logic        bubble;
  } if_out_t;
  typedef struct packed {
    logic        bubble;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_read;
    logic [31:0] result;
  } ex_out_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bubble;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        branch;
    logic [31:0] branch_dest;
    logic        stall;
  } id_out_t;
endpackage

// File: rtl/stage_id_regfile.sv
// regfile: two combinational read ports, one synchronous write port, r0 reads zero
module regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [NREGS];
  always_ff @(posedge clk)
    if (we && wa != 5'd0) mem[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : mem[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : mem[ra2];
endmodule

// File: rtl/stage_id.sv
// stage_id: br32 decode stage with operand forwarding, load-use stall and branch resolution
module stage_id
  import pipeline_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  if_out_t     in,
  input  logic        exn,
  input  ex_out_t     EX,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output id_out_t     out
);
  logic [31:0] pc_q, instr_q, rf1, rf2, v1, v2, imm, seq;
  logic bub_q, use1, use2, we, mr, mw, ex_fwd, stall, taken, branch, kill, unused_nextpc;
  logic [5:0] op;
  logic [4:0] rs1, rs2;
  alu_op_t alu;
  assign unused_nextpc = ^in.nextpc;
  always_ff @(posedge clk)
    if (rst || exn || branch) bub_q <= 1'b1;
    else if (!stall) begin
      pc_q <= in.pc;
      instr_q <= in.instr;
      bub_q <= in.bubble;
    end
  assign op = instr_q[31:26];
  assign rs1 = instr_q[20:16];
  assign rs2 = instr_q[15:11];
  always_comb begin
    {use1, use2, we, mr, mw} = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: {use1, use2, we} = 3'b111;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: {use1, we} = 2'b11;
      OP_LW: {use1, we, mr} = 3'b111;
      OP_SW: {use1, use2, mw} = 3'b111;
      OP_BEQ, OP_BNE: {use1, use2} = 2'b11;
      OP_JAL: we = 1'b1;
      OP_JR: use1 = 1'b1;
      default: ;
    endcase
  end
  assign alu = op == OP_SUB ? ALU_SUB :
               op inside {OP_AND, OP_ANDI} ? ALU_AND :
               op inside {OP_OR, OP_ORI} ? ALU_OR :
               op inside {OP_XOR, OP_XORI} ? ALU_XOR : ALU_ADD;
  assign imm = op inside {OP_ANDI, OP_ORI, OP_XORI} ? {16'b0, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};
  regfile #(.NREGS(NREGS)) u_rf (
    .clk, .we(wb_we), .wa(wb_rd), .wd(wb_data), .ra1(rs1), .ra2(rs2), .rd1(rf1), .rd2(rf2)
  );
  // loads are excluded from EX forwarding: their data only exists after memory
  assign ex_fwd = !EX.bubble && EX.reg_we && !EX.mem_read;
  assign v1 = rs1 == 5'd0 ? '0 : (ex_fwd && EX.rd == rs1) ? EX.result : (wb_we && wb_rd == rs1) ? wb_data : rf1;
  assign v2 = rs2 == 5'd0 ? '0 : (ex_fwd && EX.rd == rs2) ? EX.result : (wb_we && wb_rd == rs2) ? wb_data : rf2;
  assign stall = !bub_q && !EX.bubble && EX.mem_read && EX.rd != 5'd0 &&
                 ((use1 && EX.rd == rs1) || (use2 && EX.rd == rs2));
  assign kill = bub_q || stall || exn;
  assign seq = pc_q + 32'd4;
  assign taken = op == OP_BEQ ? v1 == v2 : op == OP_BNE ? v1 != v2 : op inside {OP_JAL, OP_JR};
  assign branch = !kill && taken;
  always_comb begin
    out.pc = pc_q;
    out.instr = instr_q;
    out.bubble = kill;
    out.rd = op == OP_JAL ? 5'd31 : instr_q[25:21];
    out.reg_we = we && !kill;
    out.mem_read = mr && !kill;
    out.mem_write = mw && !kill;
    out.rs1_val = op == OP_JAL ? seq : v1;
    out.rs2_val = op == OP_JAL ? '0 : v2;
    out.imm = imm;
    out.alu_op = alu;
    out.branch = branch;
    out.branch_dest = op == OP_JR ? v1 & ~32'd3 : seq + (imm << 2);
    out.stall = stall;
  end
endmodule

// File: tb/tb_stage_id.sv
// tb_stage_id: directed and random checks of stage_id against a behavioural decode model
module tb_stage_id;
  import pipeline_pkg::*;
  logic clk = 1'b0;
  logic rst, exn, wb_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  if_out_t in;
  ex_out_t EX;
  id_out_t out;
  int compared = 0;
  int mismatched = 0;
  logic mbub = 1'b1;
  logic [31:0] mpc, minstr;
  logic [31:0] regs [32];
  id_out_t e;
  logic [5:0] ops [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_ANDI, OP_ORI,
                           OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_JR};
  logic [5:0] op6;

  always #5 clk = ~clk;

  stage_id #(.NREGS(32)) dut (
    .clk, .rst, .in, .exn, .EX, .wb_we, .wb_rd, .wb_data, .out
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (!EX.bubble && EX.reg_we && !EX.mem_read && EX.rd == r) return EX.result;
    if (wb_we && wb_rd == r) return wb_data;
    return regs[r];
  endfunction

  function automatic id_out_t model();
    id_out_t m;
    logic [5:0] op;
    logic [4:0] s1, s2;
    logic arith, imop, logical, u1, u2, hz, live;
    logic [31:0] a, b;
    m = '0;
    op = minstr[31:26];
    s1 = minstr[20:16];
    s2 = minstr[15:11];
    arith = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    imop = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI};
    logical = op inside {OP_ANDI, OP_ORI, OP_XORI};
    u1 = arith || imop || op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JR};
    u2 = arith || op inside {OP_SW, OP_BEQ, OP_BNE};
    a = opnd(s1);
    b = opnd(s2);
    hz = !mbub && !EX.bubble && EX.mem_read && EX.rd != 5'd0 &&
         ((u1 && EX.rd == s1) || (u2 && EX.rd == s2));
    live = !(mbub || hz || exn);
    m.pc = mpc;
    m.instr = minstr;
    m.bubble = !live;
    m.stall = hz;
    m.rd = op == OP_JAL ? 5'd31 : minstr[25:21];
    m.reg_we = live && (arith || imop || op == OP_LW || op == OP_JAL);
    m.mem_read = live && op == OP_LW;
    m.mem_write = live && op == OP_SW;
    m.imm = logical ? 32'(minstr[15:0]) : 32'($signed(minstr[15:0]));
    case (op)
      OP_SUB: m.alu_op = ALU_SUB;
      OP_AND, OP_ANDI: m.alu_op = ALU_AND;
      OP_OR, OP_ORI: m.alu_op = ALU_OR;
      OP_XOR, OP_XORI: m.alu_op = ALU_XOR;
      default: m.alu_op = ALU_ADD;
    endcase
    m.rs1_val = op == OP_JAL ? mpc + 32'd4 : a;
    m.rs2_val = op == OP_JAL ? 32'd0 : b;
    m.branch = live && ((op == OP_BEQ && a == b) || (op == OP_BNE && a != b) || op == OP_JAL || op == OP_JR);
    m.branch_dest = op == OP_JR ? {a[31:2], 2'b00} : mpc + 32'd4 + m.imm * 32'd4;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in = '{pc: 32'd0, nextpc: 32'd4, instr: 32'd0, bubble: 1'b1};
    exn = 1'b0;
    EX = '{bubble: 1'b1, rd: 5'd0, reg_we: 1'b0, mem_read: 1'b0, result: 32'd0};
    wb_we = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    in = '{pc: pc, nextpc: pc + 32'd4, instr: instr, bubble: 1'b0};
  endtask

  task automatic sample();
    @(negedge clk);
    e = model();
    chk("bubble", 32'(out.bubble), 32'(e.bubble));
    chk("stall", 32'(out.stall), 32'(e.stall));
    chk("branch", 32'(out.branch), 32'(e.branch));
    chk("reg_we", 32'(out.reg_we), 32'(e.reg_we));
    chk("mem_read", 32'(out.mem_read), 32'(e.mem_read));
    chk("mem_write", 32'(out.mem_write), 32'(e.mem_write));
    if (!mbub) begin
      chk("pc", out.pc, e.pc);
      chk("instr", out.instr, e.instr);
    end
    if (!e.bubble) begin
      chk("rd", 32'(out.rd), 32'(e.rd));
      chk("rs1_val", out.rs1_val, e.rs1_val);
      chk("rs2_val", out.rs2_val, e.rs2_val);
      chk("imm", out.imm, e.imm);
      chk("alu_op", 32'(out.alu_op), 32'(e.alu_op));
    end
    if (e.branch) chk("branch_dest", out.branch_dest, e.branch_dest);
  endtask

  task automatic adv();
    if (rst || exn) mbub = 1'b1;
    else if (!e.stall) begin
      if (e.branch) mbub = 1'b1;
      else begin
        mpc = in.pc;
        minstr = in.instr;
        mbub = in.bubble;
      end
    end
    if (wb_we && wb_rd != 5'd0) regs[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    regs[0] = 32'd0;
    @(posedge clk);
    #1;
    repeat (2) begin
      sample();
      chk("rst_bubble", 32'(out.bubble), 32'd1);
      chk("rst_branch", 32'(out.branch), 32'd0);
      chk("rst_stall", 32'(out.stall), 32'd0);
      adv();
    end
    rst = 1'b0;
    for (int r = 1; r < 32; r++) begin
      wb_we = 1'b1;
      wb_rd = 5'(r);
      wb_data = r == 3 ? 32'hDEAD : $urandom;
      sample();
      adv();
    end
    idle();
    feed(32'h100, enc(OP_ADD, 5'd6, 5'd1, 16'h1000));
    sample();
    chk("first_in_not_yet", 32'(out.bubble), 32'd1);
    adv();
    idle();
    sample();
    chk("first_in_bubble", 32'(out.bubble), 32'd0);
    chk("first_in_pc", out.pc, 32'h100);
    adv();
    feed(32'h200, enc(OP_ADD, 5'd6, 5'd5, 16'h0800));
    sample();
    adv();
    EX = '{bubble: 1'b0, rd: 5'd5, reg_we: 1'b1, mem_read: 1'b1, result: 32'd0};
    feed(32'h204, enc(OP_ADD, 5'd7, 5'd0, 16'h0000));
    sample();
    chk("lu_stall", 32'(out.stall), 32'd1);
    chk("lu_bubble", 32'(out.bubble), 32'd1);
    adv();
    EX.bubble = 1'b1;
    sample();
    chk("lu_clear", 32'(out.stall), 32'd0);
    chk("lu_issue", 32'(out.bubble), 32'd0);
    chk("lu_pc", out.pc, 32'h200);
    adv();
    idle();
    feed(32'h300, enc(OP_ADD, 5'd8, 5'd3, 16'h2000));
    sample();
    adv();
    idle();
    EX = '{bubble: 1'b0, rd: 5'd3, reg_we: 1'b1, mem_read: 1'b0, result: 32'h1234};
    wb_we = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'hDEAD;
    sample();
    chk("ex_fwd", out.rs1_val, 32'h1234);
    adv();
    idle();
    feed(32'h100, enc(OP_BEQ, 5'd0, 5'd31, 16'hFFFC));
    sample();
    adv();
    feed(32'h104, enc(OP_ADD, 5'd1, 5'd2, 16'h1800));
    sample();
    chk("beq_taken", 32'(out.branch), 32'd1);
    chk("beq_dest", out.branch_dest, 32'hF4);
    adv();
    feed(32'hF4, enc(OP_ADD, 5'd0, 5'd0, 16'h0000));
    sample();
    chk("beq_slot", 32'(out.bubble), 32'd1);
    adv();
    idle();
    sample();
    chk("beq_target_pc", out.pc, 32'hF4);
    adv();
    feed(32'h400, enc(OP_JR, 5'd0, 5'd9, 16'h0000));
    sample();
    adv();
    idle();
    EX = '{bubble: 1'b0, rd: 5'd9, reg_we: 1'b1, mem_read: 1'b0, result: 32'hFFFF_FFFF};
    sample();
    chk("jr_taken", 32'(out.branch), 32'd1);
    chk("jr_dest", out.branch_dest, 32'hFFFF_FFFC);
    adv();
    idle();
    feed(32'hFFFF_FFFC, enc(OP_BEQ, 5'd0, 5'd0, 16'h0000));
    sample();
    adv();
    idle();
    sample();
    chk("beq_wrap", out.branch_dest, 32'h0);
    adv();
    feed(32'h600, enc(OP_ADD, 5'd6, 5'd5, 16'h0800));
    sample();
    adv();
    idle();
    EX = '{bubble: 1'b0, rd: 5'd5, reg_we: 1'b1, mem_read: 1'b1, result: 32'd0};
    exn = 1'b1;
    sample();
    chk("flush_branch", 32'(out.branch), 32'd0);
    adv();
    idle();
    sample();
    chk("flush_bubble", 32'(out.bubble), 32'd1);
    chk("flush_stall", 32'(out.stall), 32'd0);
    chk("flush_branch_next", 32'(out.branch), 32'd0);
    adv();
    feed(32'h500, enc(OP_JAL, 5'd0, 5'd0, 16'h0010));
    sample();
    adv();
    idle();
    exn = 1'b1;
    sample();
    chk("jal_flush", 32'(out.branch), 32'd0);
    adv();
    idle();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) == 0;
      exn = $urandom_range(0, 19) == 0;
      op6 = $urandom_range(0, 9) == 0 ? 6'($urandom) : ops[$urandom_range(0, 14)];
      in.pc = $urandom & ~32'd3;
      in.nextpc = in.pc + 32'd4;
      in.instr = enc(op6, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     {5'($urandom_range(0, 7)), 11'($urandom)});
      in.bubble = $urandom_range(0, 4) == 0;
      EX.bubble = $urandom_range(0, 2) == 0;
      EX.rd = 5'($urandom_range(0, 7));
      EX.reg_we = 1'($urandom);
      EX.mem_read = 1'($urandom);
      EX.result = $urandom;
      wb_we = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      sample();
      adv();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
